// File: rtl/core_debug_master.sv
// ---------------------------------------------------------------------------
// core_debug_master
//
// Initiator side of the core debug command/response interface. A host (debug
// bridge or test controller) posts one request at a time. The block drives
// the command port of the core debug responder, waits for the response under
// a timeout, and returns one result per command to the host. Dump mode walks
// the register targets 0..P_DUMP_LAST with READ_REG commands and returns one
// result per target.
//
// Ports
//   iCLOCK, inRESET        rising-edge clock, asynchronous active-low reset
//   iHOST_REQ              request strobe; sampled only while idle
//   iHOST_DUMP             1 = register dump; command/target/data ignored
//   iHOST_COMMAND/TARGET/DATA   single-command fields
//   oHOST_BUSY             high while a command or dump is in progress
//   oHOST_VALID            one-cycle result strobe
//   oHOST_ERROR/TIMEOUT/LAST/TARGET/DATA   result fields, held until the
//                          next result
//   oCMD_REQ, iCMD_BUSY    command handshake to the responder
//   oCMD_COMMAND/TARGET/DATA    command fields, stable while oCMD_REQ is high
//   iRESP_VALID/ERROR/DATA response strobe and payload from the responder
//   oDEBUG_STATE           current FSM state (0 idle, 1 issue, 2 wait)
//
// Command handshake: oCMD_REQ acts as valid and !iCMD_BUSY as ready. A
// command is accepted in the cycle where oCMD_REQ=1 and iCMD_BUSY=0; the
// command fields do not change while oCMD_REQ is high and not yet accepted.
// The response side has no back-pressure: iRESP_VALID is a one-cycle strobe
// that is only honoured while waiting for a response.
// ---------------------------------------------------------------------------
module core_debug_master #(
    parameter int P_TIMEOUT   = 1024,
    parameter int P_TIMEOUT_W = 16,
    parameter int P_DUMP_LAST = 37
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    // host side
    input  logic        iHOST_REQ,
    output logic        oHOST_BUSY,
    input  logic        iHOST_DUMP,
    input  logic [3:0]  iHOST_COMMAND,
    input  logic [11:0] iHOST_TARGET,
    input  logic [31:0] iHOST_DATA,
    output logic        oHOST_VALID,
    output logic        oHOST_ERROR,
    output logic        oHOST_TIMEOUT,
    output logic        oHOST_LAST,
    output logic [11:0] oHOST_TARGET,
    output logic [31:0] oHOST_DATA,
    // responder command port
    output logic        oCMD_REQ,
    input  logic        iCMD_BUSY,
    output logic [3:0]  oCMD_COMMAND,
    output logic [11:0] oCMD_TARGET,
    output logic [31:0] oCMD_DATA,
    // responder response port
    input  logic        iRESP_VALID,
    input  logic        iRESP_ERROR,
    input  logic [31:0] iRESP_DATA,
    // observability
    output logic [1:0]  oDEBUG_STATE
);

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_ISSUE = 2'd1,
        L_WAIT  = 2'd2
    } state_t;

    localparam logic [P_TIMEOUT_W-1:0] LP_TIMER_END = P_TIMEOUT_W'(P_TIMEOUT - 1);
    localparam logic [P_TIMEOUT_W-1:0] LP_TIMER_MAX = '1;
    localparam logic [11:0]            LP_DUMP_LAST = 12'(P_DUMP_LAST);
    localparam logic [3:0]             LP_READ_REG  = 4'h0;

    state_t                 r_state;
    logic                   r_dump;
    logic [3:0]             r_command;
    logic [11:0]            r_target;
    logic [31:0]            r_data;
    logic [P_TIMEOUT_W-1:0] r_timer;

    logic                   r_host_valid;
    logic                   r_host_error;
    logic                   r_host_timeout;
    logic                   r_host_last;
    logic [11:0]            r_host_target;
    logic [31:0]            r_host_data;

    logic                   w_accept;
    logic                   w_timer_end;
    logic                   w_dump_more;
    logic [P_TIMEOUT_W-1:0] w_timer_next;

    // Acceptance can only happen while the request is being presented.
    assign w_accept    = (r_state == L_ISSUE) && !iCMD_BUSY;
    assign w_timer_end = (r_timer == LP_TIMER_END);
    // A dump continues only on an error-free response below the last target;
    // the bound check also keeps the target from ever passing P_DUMP_LAST.
    assign w_dump_more = r_dump && !iRESP_ERROR && (r_target < LP_DUMP_LAST);
    // Saturating increment: the timer never wraps back into a "fresh" value.
    assign w_timer_next = (r_timer == LP_TIMER_MAX) ? r_timer : r_timer + 1'b1;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state        <= L_IDLE;
            r_dump         <= 1'b0;
            r_command      <= 4'h0;
            r_target       <= 12'h000;
            r_data         <= 32'h0000_0000;
            r_timer        <= '0;
            r_host_valid   <= 1'b0;
            r_host_error   <= 1'b0;
            r_host_timeout <= 1'b0;
            r_host_last    <= 1'b0;
            r_host_target  <= 12'h000;
            r_host_data    <= 32'h0000_0000;
        end else begin
            // Result strobe is a single-cycle pulse; the fields hold.
            r_host_valid <= 1'b0;

            case (r_state)
                L_IDLE: begin
                    if (iHOST_REQ) begin
                        r_state <= L_ISSUE;
                        r_timer <= '0;
                        r_dump  <= iHOST_DUMP;
                        if (iHOST_DUMP) begin
                            r_command <= LP_READ_REG;
                            r_target  <= 12'h000;
                            r_data    <= 32'h0000_0000;
                        end else begin
                            r_command <= iHOST_COMMAND;
                            r_target  <= iHOST_TARGET;
                            r_data    <= iHOST_DATA;
                        end
                    end
                end

                L_ISSUE: begin
                    // Acceptance takes priority over a timeout in the same
                    // cycle: the command is in flight and gets a full window.
                    if (w_accept) begin
                        r_state <= L_WAIT;
                        r_timer <= '0;
                    end else if (w_timer_end) begin
                        r_state        <= L_IDLE;
                        r_host_valid   <= 1'b1;
                        r_host_error   <= 1'b1;
                        r_host_timeout <= 1'b1;
                        r_host_last    <= 1'b1;
                        r_host_target  <= r_target;
                        r_host_data    <= 32'h0000_0000;
                    end else begin
                        r_timer <= w_timer_next;
                    end
                end

                L_WAIT: begin
                    // A response arriving on the timeout cycle still counts.
                    if (iRESP_VALID) begin
                        r_host_valid   <= 1'b1;
                        r_host_error   <= iRESP_ERROR;
                        r_host_timeout <= 1'b0;
                        r_host_target  <= r_target;
                        r_host_data    <= iRESP_DATA;
                        if (w_dump_more) begin
                            r_state     <= L_ISSUE;
                            r_target    <= r_target + 12'd1;
                            r_timer     <= '0;
                            r_host_last <= 1'b0;
                        end else begin
                            r_state     <= L_IDLE;
                            r_host_last <= 1'b1;
                        end
                    end else if (w_timer_end) begin
                        r_state        <= L_IDLE;
                        r_host_valid   <= 1'b1;
                        r_host_error   <= 1'b1;
                        r_host_timeout <= 1'b1;
                        r_host_last    <= 1'b1;
                        r_host_target  <= r_target;
                        r_host_data    <= 32'h0000_0000;
                    end else begin
                        r_timer <= w_timer_next;
                    end
                end

                default: begin
                    r_state <= L_IDLE;
                end
            endcase
        end
    end

    assign oHOST_BUSY    = (r_state != L_IDLE);
    assign oHOST_VALID   = r_host_valid;
    assign oHOST_ERROR   = r_host_error;
    assign oHOST_TIMEOUT = r_host_timeout;
    assign oHOST_LAST    = r_host_last;
    assign oHOST_TARGET  = r_host_target;
    assign oHOST_DATA    = r_host_data;

    assign oCMD_REQ      = (r_state == L_ISSUE);
    assign oCMD_COMMAND  = r_command;
    assign oCMD_TARGET   = r_target;
    assign oCMD_DATA     = r_data;

    assign oDEBUG_STATE  = r_state;

endmodule

// File: tb/tb_core_debug_master.sv
// ---------------------------------------------------------------------------
// tb_core_debug_master
//
// A responder model answers accepted commands after a configurable busy time
// and latency with data = (target * 0x10) ^ salt, raising an error on one
// chosen target. Each host request pushes its expected results into exp_q;
// a monitor pops one entry per oHOST_VALID pulse and checks fields, latency
// and busy state.
// ---------------------------------------------------------------------------
module tb_core_debug_master;

    localparam int P_TIMEOUT   = 40;
    localparam int P_TIMEOUT_W = 6;
    localparam int P_DUMP_LAST = 37;
    localparam int W           = 47;   // {target12, data32, err, tmo, last}

    logic        iCLOCK;
    logic        inRESET;
    logic        iHOST_REQ;
    logic        oHOST_BUSY;
    logic        iHOST_DUMP;
    logic [3:0]  iHOST_COMMAND;
    logic [11:0] iHOST_TARGET;
    logic [31:0] iHOST_DATA;
    logic        oHOST_VALID;
    logic        oHOST_ERROR;
    logic        oHOST_TIMEOUT;
    logic        oHOST_LAST;
    logic [11:0] oHOST_TARGET;
    logic [31:0] oHOST_DATA;
    logic        oCMD_REQ;
    logic        iCMD_BUSY;
    logic [3:0]  oCMD_COMMAND;
    logic [11:0] oCMD_TARGET;
    logic [31:0] oCMD_DATA;
    logic        iRESP_VALID;
    logic        iRESP_ERROR;
    logic [31:0] iRESP_DATA;
    logic [1:0]  oDEBUG_STATE;

    core_debug_master #(
        .P_TIMEOUT   (P_TIMEOUT),
        .P_TIMEOUT_W (P_TIMEOUT_W),
        .P_DUMP_LAST (P_DUMP_LAST)
    ) dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iHOST_REQ     (iHOST_REQ),
        .oHOST_BUSY    (oHOST_BUSY),
        .iHOST_DUMP    (iHOST_DUMP),
        .iHOST_COMMAND (iHOST_COMMAND),
        .iHOST_TARGET  (iHOST_TARGET),
        .iHOST_DATA    (iHOST_DATA),
        .oHOST_VALID   (oHOST_VALID),
        .oHOST_ERROR   (oHOST_ERROR),
        .oHOST_TIMEOUT (oHOST_TIMEOUT),
        .oHOST_LAST    (oHOST_LAST),
        .oHOST_TARGET  (oHOST_TARGET),
        .oHOST_DATA    (oHOST_DATA),
        .oCMD_REQ      (oCMD_REQ),
        .iCMD_BUSY     (iCMD_BUSY),
        .oCMD_COMMAND  (oCMD_COMMAND),
        .oCMD_TARGET   (oCMD_TARGET),
        .oCMD_DATA     (oCMD_DATA),
        .iRESP_VALID   (iRESP_VALID),
        .iRESP_ERROR   (iRESP_ERROR),
        .iRESP_DATA    (iRESP_DATA),
        .oDEBUG_STATE  (oDEBUG_STATE)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int cyc = 0;
    always @(posedge iCLOCK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [W-1:0] exp_q[$];

    // responder configuration
    int          cfg_busy    = 0;
    int          cfg_lat     = 0;
    int          cfg_err_tgt = -1;
    logic [31:0] cfg_salt    = 32'h0;

    // expected command for the current host request
    bit          cur_dump;
    logic [3:0]  cur_cmd;
    logic [11:0] cur_tgt;
    logic [31:0] cur_data;
    int          exp_acc_n;

    // observations
    int acc_in_req      = 0;
    int req_cycles      = 0;
    int first_req_cycle = 0;
    int acc_cycle       = 0;
    int tmo_base        = 0;
    int resp_cycle      = 0;
    int host_req_cycle  = 0;
    int last_pulse_cycle = 0;
    int pulses          = 0;
    bit pend            = 0;
    bit in_req          = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rsp_fn(input int t);
        return (32'(t) * 32'h10) ^ cfg_salt;
    endfunction

    function automatic logic [W-1:0] pack(input int t, input logic [31:0] d,
                                          input bit e, input bit to, input bit last);
        return {12'(t), d, e, to, last};
    endfunction

    // ---------------- responder model ----------------
    initial begin : responder
        int busy_left;
        int lat_left;
        int p_tgt;
        logic [47:0] cap;
        logic [3:0]  exp_c;
        logic [11:0] exp_t;
        logic [31:0] exp_d;
        busy_left = 0;
        lat_left  = 0;
        p_tgt     = 0;
        cap       = '0;
        iCMD_BUSY   = 1'b0;
        iRESP_VALID = 1'b0;
        iRESP_ERROR = 1'b0;
        iRESP_DATA  = 32'h0;
        forever begin
            @(negedge iCLOCK);
            iRESP_VALID = 1'b0;
            iRESP_ERROR = 1'($urandom);
            iRESP_DATA  = $urandom;
            if (pend) begin
                if (lat_left == 0) begin
                    iRESP_VALID = 1'b1;
                    iRESP_ERROR = (p_tgt == cfg_err_tgt);
                    iRESP_DATA  = rsp_fn(p_tgt);
                    resp_cycle  = cyc;
                    pend        = 0;
                end else begin
                    lat_left--;
                end
            end
            if (oCMD_REQ) begin
                if (!in_req) begin
                    in_req          = 1;
                    busy_left       = cfg_busy;
                    first_req_cycle = cyc;
                    req_cycles      = 0;
                    cap             = {oCMD_COMMAND, oCMD_TARGET, oCMD_DATA};
                end
                req_cycles++;
                if (req_cycles > 1)
                    check("cmd_stable", {oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}, cap);
                if (busy_left > 0) begin
                    iCMD_BUSY = 1'b1;
                    busy_left--;
                end else begin
                    iCMD_BUSY = 1'b0;
                    exp_c = cur_dump ? 4'h0 : cur_cmd;
                    exp_t = cur_dump ? 12'(acc_in_req) : cur_tgt;
                    exp_d = cur_dump ? 32'h0 : cur_data;
                    check("cmd_count", acc_in_req < exp_acc_n, 1);
                    check("cmd_fields", {oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}, {exp_c, exp_t, exp_d});
                    acc_in_req++;
                    acc_cycle = cyc;
                    tmo_base  = cyc;
                    p_tgt     = int'(oCMD_TARGET);
                    lat_left  = cfg_lat;
                    pend      = 1;
                end
            end else begin
                in_req    = 0;
                iCMD_BUSY = 1'($urandom);
            end
        end
    end

    // ---------------- result monitor / scoreboard ----------------
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge iCLOCK);
            if (oHOST_VALID) begin
                pulses++;
                last_pulse_cycle = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual target=%0h data=%0h required no pulse (cycle %0d)",
                             oHOST_TARGET, oHOST_DATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {oHOST_TARGET, oHOST_DATA, oHOST_ERROR, oHOST_TIMEOUT, oHOST_LAST}, e);
                    if (e[1])
                        check("timeout_latency", cyc, tmo_base + P_TIMEOUT + 1);
                    else
                        check("resp_latency", cyc, resp_cycle + 1);
                    check("busy_at_result", oHOST_BUSY, !e[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic host_req(input bit dump, input logic [3:0] cmd, input logic [11:0] tgt,
                            input logic [31:0] data, input int n_acc);
        @(negedge iCLOCK);
        cur_dump   = dump;
        cur_cmd    = cmd;
        cur_tgt    = tgt;
        cur_data   = data;
        exp_acc_n  = n_acc;
        acc_in_req = 0;
        iHOST_REQ     = 1'b1;
        iHOST_DUMP    = dump;
        iHOST_COMMAND = dump ? 4'($urandom) : cmd;
        iHOST_TARGET  = dump ? 12'($urandom) : tgt;
        iHOST_DATA    = dump ? $urandom : data;
        host_req_cycle = cyc;
        tmo_base       = cyc;
        @(negedge iCLOCK);
        iHOST_REQ     = 1'b0;
        iHOST_DUMP    = 1'($urandom);
        iHOST_COMMAND = 4'($urandom);
        iHOST_TARGET  = 12'($urandom);
        iHOST_DATA    = $urandom;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || oHOST_BUSY || pend) && n < budget) begin
            @(negedge iCLOCK);
            n++;
        end
        repeat (3) @(negedge iCLOCK);
        check({name, "_completed"}, n < budget, 1);
        check({name, "_cmd_total"}, acc_in_req, exp_acc_n);
        exp_q.delete();
        pend = 0;
    endtask

    task automatic push_dump(input int last_t, input int err_t);
        for (int t = 0; t <= last_t; t++)
            exp_q.push_back(pack(t, 32'(t) * 32'h10, t == err_t, 1'b0, t == last_t));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [3:0] cmd_tab [4];
        int p0;
        int n;
        cmd_tab[0] = 4'h0; cmd_tab[1] = 4'h1; cmd_tab[2] = 4'h8; cmd_tab[3] = 4'hF;

        inRESET       = 1'b0;
        iHOST_REQ     = 1'b0;
        iHOST_DUMP    = 1'b0;
        iHOST_COMMAND = 4'h0;
        iHOST_TARGET  = 12'h0;
        iHOST_DATA    = 32'h0;
        repeat (3) @(negedge iCLOCK);
        check("reset_host_outputs",
              {oHOST_BUSY, oHOST_VALID, oHOST_ERROR, oHOST_TIMEOUT, oHOST_LAST, oHOST_TARGET, oHOST_DATA}, 0);
        check("reset_cmd_outputs", {oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA, oDEBUG_STATE}, 0);
        inRESET = 1'b1;
        repeat (2) @(negedge iCLOCK);

        // Single READ_REG target 5, response 3 cycles after the request cycle.
        cfg_busy = 0; cfg_lat = 2; cfg_err_tgt = -1;
        cfg_salt = 32'hDEADBEEF ^ 32'h50;
        exp_q.push_back(pack(5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
        host_req(1'b0, 4'h0, 12'd5, 32'h0, 1);
        wait_idle("single_read", 100);
        check("read_first_req_cycle", first_req_cycle, host_req_cycle + 1);
        check("read_req_cycles", req_cycles, 1);
        check("read_result_cycle", last_pulse_cycle, host_req_cycle + 5);

        // Responder busy for 10 cycles before accepting.
        cfg_busy = 10; cfg_lat = 1; cfg_salt = 32'h1234_5678;
        exp_q.push_back(pack(12'h2A, rsp_fn(12'h2A), 1'b0, 1'b0, 1'b1));
        host_req(1'b0, 4'h1, 12'h2A, 32'hCAFE_F00D, 1);
        wait_idle("busy_hold", 100);
        check("busy_req_cycles", req_cycles, 11);
        check("busy_accept_cycle", acc_cycle, first_req_cycle + 10);

        // Full dump.
        cfg_busy = 0; cfg_lat = 1; cfg_salt = 32'h0;
        p0 = pulses;
        push_dump(P_DUMP_LAST, -1);
        host_req(1'b1, 4'h0, 12'h0, 32'h0, P_DUMP_LAST + 1);
        wait_idle("dump_full", 1000);
        check("dump_pulses", pulses - p0, P_DUMP_LAST + 1);

        // No response in time; the late response lands in idle.
        cfg_busy = 1; cfg_lat = P_TIMEOUT + 3; cfg_salt = 32'h5555_AAAA;
        exp_q.push_back(pack(12'h7FF, 32'h0, 1'b1, 1'b1, 1'b1));
        host_req(1'b0, 4'h0, 12'h7FF, 32'h0, 1);
        wait_idle("resp_timeout", 200);

        // Responder never accepts: timeout out of the issue phase.
        cfg_busy = 1000; cfg_lat = 0;
        exp_q.push_back(pack(12'h0C3, 32'h0, 1'b1, 1'b1, 1'b1));
        host_req(1'b0, 4'h8, 12'h0C3, 32'h0, 0);
        wait_idle("busy_timeout", 200);

        // Dump stopping on an error at target 3.
        cfg_busy = 0; cfg_lat = 0; cfg_salt = 32'h0; cfg_err_tgt = 3;
        push_dump(3, 3);
        host_req(1'b1, 4'h0, 12'h0, 32'h0, 4);
        wait_idle("dump_error", 200);

        // Host request during wait is ignored.
        cfg_busy = 0; cfg_lat = 8; cfg_err_tgt = -1; cfg_salt = 32'h0F0F_0F0F;
        exp_q.push_back(pack(12'h0A0, rsp_fn(12'h0A0), 1'b0, 1'b0, 1'b1));
        host_req(1'b0, 4'h0, 12'h0A0, 32'h0, 1);
        repeat (2) @(negedge iCLOCK);
        iHOST_REQ = 1'b1; iHOST_DUMP = 1'b1; iHOST_TARGET = 12'h123;
        @(negedge iCLOCK);
        iHOST_REQ = 1'b0;
        wait_idle("req_in_wait", 100);

        // Randomised single commands.
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  c;
            logic [11:0] t;
            logic [31:0] d;
            bit          er;
            c  = cmd_tab[$urandom_range(0, 3)];
            t  = 12'($urandom);
            d  = $urandom;
            er = ($urandom_range(0, 3) == 0);
            cfg_busy    = $urandom_range(0, 3);
            cfg_lat     = $urandom_range(0, 6);
            cfg_salt    = $urandom;
            cfg_err_tgt = er ? int'(t) : -1;
            exp_q.push_back(pack(t, (32'(t) * 32'h10) ^ cfg_salt, er, 1'b0, 1'b1));
            host_req(1'b0, c, t, d, 1);
            wait_idle("random_single", 100);
        end

        // Randomised dump aborted by an error.
        cfg_busy = $urandom_range(0, 2); cfg_lat = $urandom_range(0, 3); cfg_salt = 32'h0;
        cfg_err_tgt = $urandom_range(0, P_DUMP_LAST);
        push_dump(cfg_err_tgt, cfg_err_tgt);
        host_req(1'b1, 4'h0, 12'h0, 32'h0, cfg_err_tgt + 1);
        wait_idle("random_dump", 1000);

        // Reset while waiting on target 10 of a dump.
        cfg_busy = 0; cfg_lat = 5; cfg_err_tgt = -1; cfg_salt = 32'h0;
        push_dump(9, -1);
        exp_q[$] = pack(9, 32'h90, 1'b0, 1'b0, 1'b0);
        host_req(1'b1, 4'h0, 12'h0, 32'h0, 11);
        n = 0;
        while (acc_in_req < 11 && n < 500) begin
            @(negedge iCLOCK);
            n++;
        end
        check("reset_reached_target10", acc_in_req, 11);
        inRESET = 1'b0;
        check("reset_results_before", exp_q.size(), 0);
        @(negedge iCLOCK);
        check("midreset_host_outputs",
              {oHOST_BUSY, oHOST_VALID, oHOST_ERROR, oHOST_TIMEOUT, oHOST_LAST, oHOST_TARGET, oHOST_DATA}, 0);
        check("midreset_cmd_outputs", {oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA, oDEBUG_STATE}, 0);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        wait_idle("reset_dump", 100);
        repeat (5) @(negedge iCLOCK);
        check("after_reset_idle", {oHOST_BUSY, oDEBUG_STATE}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
